pc_fetch_unit: RTL and testbench

- F-stage program-counter owner for the 5-stage MIPS pipeline; the consumer of the next-PC value the branch/jump target logic produces in D.
- Registers the fetch PC and selects among reset vector, exception entry, ERET return, stall hold, D-stage redirect and sequential PC+4.
- Flags fetch-address exceptions and delay-slot membership for the fetched instruction, then hands PC and flags to the F/D pipeline register.

---
 rtl/pc_fetch_unit.sv | 139 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// F-stage program-counter owner: boot sequencing, next-PC selection, delay-slot and fetch-address-error flags.
// Optional fetch/redirect performance counters are built when FETCH_PERF_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        npc_redirect,
    input  logic        d_is_ctrl,
    input  logic [31:0] npc,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        f_valid,
    output logic        f_bd,
    output logic        f_exc_adel
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_redirect
`endif
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic        flush_r;
    logic        flush_nxt_s;
    logic        redirect_taken_s;
    logic        addr_bad_s;

    // Illegal fetch address: misaligned, or outside the instruction memory window.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        fetch_addr_bad = (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
    endfunction

    // Next-state and next-PC selection, M-stage exception/ERET above stall above D redirect.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        flush_nxt_s      = 1'b0;
        redirect_taken_s = 1'b0;
        case (state_r)
            BOOT: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (exc_req) begin
                    pc_nxt_s         = EXC_ENTRY;
                    flush_nxt_s      = 1'b1;
                    redirect_taken_s = 1'b1;
                end else if (eret) begin
                    pc_nxt_s         = epc;
                    flush_nxt_s      = 1'b1;
                    redirect_taken_s = 1'b1;
                end else if (stall) begin
                    pc_nxt_s = pc_r;
                end else if (npc_redirect) begin
                    pc_nxt_s         = npc;
                    redirect_taken_s = 1'b1;
                end else begin
                    pc_nxt_s = pc_r + 32'd4;
                end
            end
            default: begin
                state_nxt_s = BOOT;
                pc_nxt_s    = RESET_PC;
            end
        endcase
    end

    // State, PC and flush-flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= BOOT;
            pc_r    <= RESET_PC;
            flush_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            flush_r <= flush_nxt_s;
        end
    end

    // Flags for the fetched instruction; a faulting fetch becomes a NOP but keeps its flag.
    always_comb begin
        if (state_r == RUN) begin
            addr_bad_s = fetch_addr_bad(pc_r);
            f_valid    = !addr_bad_s;
            f_bd       = d_is_ctrl && !flush_r;
        end else begin
            addr_bad_s = 1'b0;
            f_valid    = 1'b0;
            f_bd       = 1'b0;
        end
    end

    assign pc         = pc_r;
    assign f_exc_adel = addr_bad_s;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_redirect_r;

    // Saturating fetch and redirect event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_r    <= 32'd0;
            perf_redirect_r <= 32'd0;
        end else begin
            if (f_valid && !stall && (perf_fetch_r != 32'hFFFF_FFFF)) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end else begin
                perf_fetch_r <= perf_fetch_r;
            end
            if (redirect_taken_s && (perf_redirect_r != 32'hFFFF_FFFF)) begin
                perf_redirect_r <= perf_redirect_r + 32'd1;
            end else begin
                perf_redirect_r <= perf_redirect_r;
            end
        end
    end

    assign perf_fetch    = perf_fetch_r;
    assign perf_redirect = perf_redirect_r;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a spec-level reference model checked every falling edge.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall = 1'b0, npc_redirect = 1'b0, d_is_ctrl = 1'b0, exc_req = 1'b0, eret = 1'b0;
    logic [31:0] npc = 32'd0, epc = 32'd0;
    logic [31:0] pc;
    logic        f_valid, f_bd, f_exc_adel;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_redirect;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .npc_redirect(npc_redirect),
        .d_is_ctrl(d_is_ctrl), .npc(npc), .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .f_valid(f_valid), .f_bd(f_bd), .f_exc_adel(f_exc_adel)
`ifdef FETCH_PERF_EN
        , .perf_fetch(perf_fetch), .perf_redirect(perf_redirect)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch address plus "running" and "just redirected by M" facts.
    logic [31:0] m_pc;
    logic        m_run, m_flush;
    logic [31:0] m_pf, m_pr;

    function automatic logic illegal(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc <= 32'h0000_3000; m_run <= 1'b0; m_flush <= 1'b0; m_pf <= 32'd0; m_pr <= 32'd0;
        end else if (!m_run) begin
            m_run <= 1'b1;
        end else begin
            m_flush <= exc_req || eret;
            if (!illegal(m_pc) && !stall && m_pf != 32'hFFFF_FFFF) m_pf <= m_pf + 32'd1;
            if ((exc_req || eret || (!stall && npc_redirect)) && m_pr != 32'hFFFF_FFFF) m_pr <= m_pr + 32'd1;
            if (exc_req)           m_pc <= 32'h0000_4180;
            else if (eret)         m_pc <= epc;
            else if (stall)        m_pc <= m_pc;
            else if (npc_redirect) m_pc <= npc;
            else                   m_pc <= m_pc + 32'd4;
        end
    end

    // Compare DUT against model on every falling edge.
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("f_valid", {31'd0, f_valid}, {31'd0, m_run && !illegal(m_pc)});
        chk("f_bd", {31'd0, f_bd}, {31'd0, m_run && d_is_ctrl && !m_flush});
        chk("f_exc_adel", {31'd0, f_exc_adel}, {31'd0, m_run && illegal(m_pc)});
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch, m_pf);
        chk("perf_redirect", perf_redirect, m_pr);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_valid", {31'd0, f_valid}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("boot_valid", {31'd0, f_valid}, 32'd0);
        tick(); chk("run_pc0", pc, 32'h0000_3000); chk("run_valid", {31'd0, f_valid}, 32'd1);
        tick(); chk("seq_3004", pc, 32'h0000_3004);
        tick(); chk("seq_3008", pc, 32'h0000_3008);

        npc_redirect = 1'b1; npc = 32'h0000_3010;
        tick(); chk("redir_3010", pc, 32'h0000_3010);
        npc = 32'h0000_3100; stall = 1'b1;
        tick(); chk("stall_hold1", pc, 32'h0000_3010);
        tick(); chk("stall_hold2", pc, 32'h0000_3010);
        stall = 1'b0;
        tick(); chk("redir_3100", pc, 32'h0000_3100);

        npc = 32'h0000_3020;
        tick(); chk("redir_3020", pc, 32'h0000_3020);
        npc_redirect = 1'b0; exc_req = 1'b1; eret = 1'b1; stall = 1'b1; d_is_ctrl = 1'b1; epc = 32'h0000_3200;
        tick(); chk("exc_pc", pc, 32'h0000_4180); chk("exc_bd", {31'd0, f_bd}, 32'd0);
        exc_req = 1'b0; eret = 1'b0; stall = 1'b0;
        tick(); chk("post_exc_pc", pc, 32'h0000_4184); chk("post_exc_bd", {31'd0, f_bd}, 32'd1);
        d_is_ctrl = 1'b0;

        eret = 1'b1; epc = 32'h0000_3042;
        tick(); chk("eret_pc", pc, 32'h0000_3042); chk("eret_adel", {31'd0, f_exc_adel}, 32'd1);
        chk("eret_valid", {31'd0, f_valid}, 32'd0);
        eret = 1'b0; exc_req = 1'b1;
        tick(); chk("exc2_pc", pc, 32'h0000_4180); chk("exc2_adel", {31'd0, f_exc_adel}, 32'd0);
        exc_req = 1'b0; stall = 1'b1; eret = 1'b1; epc = 32'h0000_3200;
        tick(); chk("eret_over_stall", pc, 32'h0000_3200);
        eret = 1'b0;
        tick(); chk("stall_only", pc, 32'h0000_3200);
        stall = 1'b0;

        npc_redirect = 1'b1; npc = 32'h0000_2FFC;
        tick(); chk("below_lo_adel", {31'd0, f_exc_adel}, 32'd1);
        npc = 32'h0000_3000;
        tick(); chk("at_lo_adel", {31'd0, f_exc_adel}, 32'd0);
        npc = 32'h0000_6FF8;
        tick(); chk("pc_6ff8", pc, 32'h0000_6FF8);
        npc_redirect = 1'b0;
        tick(); chk("pc_6ffc", pc, 32'h0000_6FFC); chk("hi_adel", {31'd0, f_exc_adel}, 32'd0);
        tick(); chk("pc_7000", pc, 32'h0000_7000); chk("above_hi_adel", {31'd0, f_exc_adel}, 32'd1);
        chk("above_hi_valid", {31'd0, f_valid}, 32'd0);

        eret = 1'b1; epc = 32'hFFFF_FFFC;
        tick(); chk("pc_fffc", pc, 32'hFFFF_FFFC);
        eret = 1'b0;
        tick(); chk("wrap_pc", pc, 32'h0000_0000); chk("wrap_adel", {31'd0, f_exc_adel}, 32'd1);

        npc_redirect = 1'b1; npc = 32'h0000_3500;
        tick(); chk("pc_3500", pc, 32'h0000_3500);
        npc = 32'h0000_3600;
        #2 reset_n = 1'b0;
        #1 chk("async_rst_pc", pc, 32'h0000_3000); chk("async_rst_valid", {31'd0, f_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_rst", perf_fetch, 32'd0);
        chk("perf_redirect_rst", perf_redirect, 32'd0);
`endif
        #3 reset_n = 1'b1;
        #1 chk("rel_valid", {31'd0, f_valid}, 32'd0);
        tick(); chk("rel_pc", pc, 32'h0000_3000); chk("rel_valid2", {31'd0, f_valid}, 32'd1);
        tick(); chk("rel_redir", pc, 32'h0000_3600);
        npc_redirect = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
